// File: rtl/iter_div_unit.sv
// Multi-cycle restoring divider for Div/Mod/Divu/Modu. It returns the quotient and
// the remainder together over a valid/ready request/response pair.
module iter_div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_signed_i,
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] y_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] quot_o,
  output logic [DATA_W-1:0] rem_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [5:0]        r_cnt;
  logic [DATA_W-1:0] r_prem;
  logic [DATA_W-1:0] r_qsh;
  logic [DATA_W-1:0] r_dvs;
  logic              r_sign_q;
  logic              r_sign_r;
  logic              r_signed;
  logic [DATA_W-1:0] r_quot;
  logic [DATA_W-1:0] r_rem;

  logic              w_accept;
  logic              w_div_zero;
  logic              w_x_neg;
  logic              w_y_neg;
  logic [DATA_W-1:0] w_x_abs;
  logic [DATA_W-1:0] w_y_abs;
  logic [DATA_W:0]   w_shift;
  logic [DATA_W:0]   w_diff;
  logic              w_qbit;
  logic [DATA_W-1:0] w_prem_next;
  logic [DATA_W-1:0] w_qsh_next;
  logic              w_last;
  logic [DATA_W-1:0] w_quot_fix;
  logic [DATA_W-1:0] w_rem_fix;

  assign w_accept   = req_valid_i & (r_state == ST_IDLE) & ~flush_i;
  assign w_div_zero = (y_i == '0);
  assign w_x_neg    = req_signed_i & x_i[DATA_W-1];
  assign w_y_neg    = req_signed_i & y_i[DATA_W-1];
  assign w_x_abs    = w_x_neg ? -x_i : x_i;
  assign w_y_abs    = w_y_neg ? -y_i : y_i;

  // The step runs 33 bits wide, but the kept remainder is always below the
  // divisor, so it is stored in DATA_W bits.
  assign w_shift     = {r_prem, r_qsh[DATA_W-1]};
  assign w_diff      = w_shift - {1'b0, r_dvs};
  assign w_qbit      = ~w_diff[DATA_W];
  assign w_prem_next = w_qbit ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
  assign w_qsh_next  = {r_qsh[DATA_W-2:0], w_qbit};
  assign w_last      = (r_cnt == 6'(DATA_W - 1));

  assign w_quot_fix = (r_signed & r_sign_q) ? -w_qsh_next : w_qsh_next;
  assign w_rem_fix  = (r_signed & r_sign_r) ? -w_prem_next : w_prem_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    busy_o       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (w_accept) begin
          w_state_next = w_div_zero ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        busy_o = 1'b1;
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_o       = 1'b1;
        resp_valid_o = 1'b1;
        if (resp_ready_i) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (flush_i) begin
      w_state_next = ST_IDLE;
    end
  end

  // Results only change on entry to DONE, so they stay stable for the whole response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_prem   <= '0;
      r_qsh    <= '0;
      r_dvs    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_signed <= 1'b0;
      r_quot   <= '0;
      r_rem    <= '0;
    end else if (flush_i) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_sign_q <= w_x_neg ^ w_y_neg;
            r_sign_r <= w_x_neg;
            r_signed <= req_signed_i;
            r_cnt    <= '0;
            r_prem   <= '0;
            r_qsh    <= w_x_abs;
            r_dvs    <= w_y_abs;
            if (w_div_zero) begin
              r_quot <= '1;
              r_rem  <= x_i;
            end
          end
        end
        ST_CALC: begin
          r_prem <= w_prem_next;
          r_qsh  <= w_qsh_next;
          r_cnt  <= r_cnt + 6'd1;
          if (w_last) begin
            r_quot <= w_quot_fix;
            r_rem  <= w_rem_fix;
            r_cnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign quot_o = r_quot;
  assign rem_o  = r_rem;

endmodule

// File: tb/tb_iter_div_unit.sv
// Bench for iter_div_unit: directed cases plus randomized operands checked against
// a plain-arithmetic reference model, with one per-cycle response compare process.
module tb_iter_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_signed_i = 1'b0;
  logic [31:0] x_i = '0;
  logic [31:0] y_i = '0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [31:0] quot_o;
  logic [31:0] rem_o;
  logic        busy_o;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  iter_div_unit #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_signed_i (req_signed_i),
    .x_i          (x_i),
    .y_i          (y_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .quot_o       (quot_o),
    .rem_o        (rem_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: language division, with the two cases the hardware defines itself.
  function automatic void refDiv(input logic [31:0] x, input logic [31:0] y, input logic s,
                                 output logic [31:0] q, output logic [31:0] r);
    logic signed [31:0] sx;
    logic signed [31:0] sy;
    sx = x;
    sy = y;
    if (y == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = x;
    end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (s) begin
      q = sx / sy;
      r = sx % sy;
    end else begin
      q = x / y;
      r = x % y;
    end
  endfunction

  task automatic pinModel(input string name, input logic [31:0] x, input logic [31:0] y,
                          input logic s, input logic [31:0] eq, input logic [31:0] er);
    logic [31:0] q;
    logic [31:0] r;
    refDiv(x, y, s, q, r);
    checkOutput({name, "_model_q"}, q, eq);
    checkOutput({name, "_model_r"}, r, er);
  endtask

  // Every cycle a response is shown it must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && resp_valid_o === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL spurious_resp: resp_valid_o=1, expected 0 (nothing pending)");
      end else begin
        checkOutput("quot", quot_o, expQ[0].q);
        checkOutput("rem", rem_o, expQ[0].r);
        checkOutput("ready_in_done", {31'b0, req_ready_o}, 32'd0);
        if (resp_ready_i || flush_i) begin
          void'(expQ.pop_front());
        end
      end
    end
  end

  task automatic startReq(input logic [31:0] x, input logic [31:0] y, input logic s);
    exp_t e;
    for (int i = 0; i < 60 && req_ready_o !== 1'b1; i++) begin
      @(posedge clk);
      #1;
    end
    if (req_ready_o !== 1'b1) begin
      checkOutput("req_ready_wait", {31'b0, req_ready_o}, 32'd1);
    end
    refDiv(x, y, s, e.q, e.r);
    expQ.push_back(e);
    x_i          = x;
    y_i          = y;
    req_signed_i = s;
    req_valid_i  = 1'b1;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input logic s,
                               input int stall);
    int lat;
    bit seen;
    resp_ready_i = (stall == 0);
    startReq(x, y, s);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (resp_valid_o === 1'b1) begin
        seen = 1'b1;
      end else begin
        checkOutput("busy_calc", {31'b0, busy_o}, 32'd1);
      end
    end
    checkOutput("latency", 32'(lat), (y == 32'd0) ? 32'd1 : 32'd33);
    if (!seen) begin
      @(posedge clk);
      #1;
      flush_i = 1'b1;
      @(posedge clk);
      #1;
      flush_i = 1'b0;
      expQ.delete();
      resp_ready_i = 1'b0;
    end else if (stall == 0) begin
      @(posedge clk);
      #1;
      resp_ready_i = 1'b0;
    end else begin
      repeat (stall) @(posedge clk);
      #1;
      resp_ready_i = 1'b1;
      @(posedge clk);
      #1;
      resp_ready_i = 1'b0;
    end
  endtask

  initial begin
    #3_000_000;
    errors++;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [31:0] edgeVals [6];
    logic [31:0] rx;
    logic [31:0] ry;
    logic        rs;
    int          st;
    edgeVals = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd2};

    pinModel("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
    pinModel("sm7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    pinModel("s7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1);
    pinModel("sm7_m2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd3, 32'hFFFF_FFFF);
    pinModel("um7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1);
    pinModel("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
    pinModel("dz", 32'h1234, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234);

    #1;
    checkOutput("rst_req_ready", {31'b0, req_ready_o}, 32'd1);
    checkOutput("rst_resp_valid", {31'b0, resp_valid_o}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy_o}, 32'd0);
    checkOutput("rst_quot", quot_o, 32'd0);
    checkOutput("rst_rem", rem_o, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed cases");
    applyStimulus(32'd100, 32'd7, 1'b0, 5);
    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b1, 1);
    applyStimulus(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 0);
    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b0, 0);
    applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b0, 0);
    applyStimulus(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0, 2);
    applyStimulus(32'h1234, 32'd0, 1'b0, 0);
    applyStimulus(32'h1234, 32'd0, 1'b1, 3);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);

    $display("[TB] flush during CALC");
    resp_ready_i = 1'b0;
    startReq(32'd1000, 32'd9, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    flush_i = 1'b1;
    expQ.delete();
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    @(negedge clk);
    checkOutput("flush_resp_valid", {31'b0, resp_valid_o}, 32'd0);
    checkOutput("flush_req_ready", {31'b0, req_ready_o}, 32'd1);
    checkOutput("flush_busy", {31'b0, busy_o}, 32'd0);
    applyStimulus(32'd20, 32'd3, 1'b0, 0);

    $display("[TB] flush coincident with request");
    @(posedge clk);
    #1;
    x_i         = 32'd5;
    y_i         = 32'd1;
    req_valid_i = 1'b1;
    flush_i     = 1'b1;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    flush_i     = 1'b0;
    @(negedge clk);
    checkOutput("noacc_busy", {31'b0, busy_o}, 32'd0);
    checkOutput("noacc_req_ready", {31'b0, req_ready_o}, 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("noacc_resp_valid", {31'b0, resp_valid_o}, 32'd0);

    $display("[TB] reset during CALC");
    resp_ready_i = 1'b0;
    @(posedge clk);
    #1;
    startReq(32'h1234_5678, 32'd3, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    expQ.delete();
    #1;
    checkOutput("amid_req_ready", {31'b0, req_ready_o}, 32'd1);
    checkOutput("amid_resp_valid", {31'b0, resp_valid_o}, 32'd0);
    checkOutput("amid_busy", {31'b0, busy_o}, 32'd0);
    checkOutput("amid_quot", quot_o, 32'd0);
    checkOutput("amid_rem", rem_o, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] random operands");
    for (int i = 0; i < 1200; i++) begin
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0: begin rx = $urandom; ry = 32'd0; end
        1: begin rx = $urandom; ry = 32'($urandom_range(1, 15)); end
        2: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
        3: begin
          rx = edgeVals[$urandom_range(0, 5)];
          ry = edgeVals[$urandom_range(0, 5)];
        end
        default: begin rx = $urandom; ry = $urandom >> $urandom_range(0, 31); end
      endcase
      st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      applyStimulus(rx, ry, rs, st);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
